rf_writeback_arb: RTL

- Write-side front end for the gpr and fpr register files; drives both single write ports.
- Port A: single-cycle pipeline result, always accepted, highest priority.
- Port B: long-latency unit results (FP, divide), valid/ready handshake, buffered in a DEPTH-entry FIFO.
- FIFO drains into whichever file port A leaves free. Exposes a pending-write query for hazard stalls.

---
 rtl/rf_writeback_arb.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rf_writeback_arb.sv
// Write-side arbiter for the gpr/fpr register files: port A writes directly, port B results
// queue in a small FIFO that drains into whichever file port A leaves free.
module rf_writeback_arb #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          a_valid,
   input  logic          a_is_fp,
   input  logic [4:0]    a_rd,
   input  logic [31:0]   a_data,
   input  logic          b_valid,
   output logic          b_ready,
   input  logic          b_is_fp,
   input  logic [4:0]    b_rd,
   input  logic [31:0]   b_data,
   input  logic          flush,
   output logic          gpr_reg_write,
   output logic [4:0]    gpr_write_reg,
   output logic [31:0]   gpr_write_data,
   output logic          fpr_reg_write,
   output logic [4:0]    fpr_write_reg,
   output logic [31:0]   fpr_write_data,
   input  logic          chk_is_fp,
   input  logic [4:0]    chk_rd,
   output logic          chk_busy,
   output logic [CW-1:0] count
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [DEPTH-1:0] fp_q;
   logic [4:0]       rd_q   [DEPTH];
   logic [31:0]      data_q [DEPTH];

   logic        a_gpr, a_fpr, head_fp, head_blocked, pop, push, head_wr, full, busy;
   logic [4:0]  head_rd;
   logic [31:0] head_data;

   assign head_fp   = fp_q[rd_ptr_q];
   assign head_rd   = rd_q[rd_ptr_q];
   assign head_data = data_q[rd_ptr_q];

   // A write to gpr x0 is dropped and never claims the gpr port.
   assign a_gpr        = !reset && a_valid && !a_is_fp && (a_rd != 5'd0);
   assign a_fpr        = !reset && a_valid && a_is_fp;
   assign head_blocked = head_fp ? a_fpr : a_gpr;
   assign pop          = (count_q != '0) && !flush && !head_blocked;
   assign head_wr      = pop && (head_fp || (head_rd != 5'd0));
   assign full         = (count_q == CW'(DEPTH));
   assign push         = b_valid && !full && !flush;
   assign b_ready      = !full;
   assign count        = count_q;

   always_comb begin
      gpr_reg_write  = 1'b0;
      gpr_write_reg  = 5'd0;
      gpr_write_data = 32'd0;
      fpr_reg_write  = 1'b0;
      fpr_write_reg  = 5'd0;
      fpr_write_data = 32'd0;
      if (a_gpr) begin
         gpr_reg_write  = 1'b1;
         gpr_write_reg  = a_rd;
         gpr_write_data = a_data;
      end else if (head_wr && !head_fp) begin
         gpr_reg_write  = 1'b1;
         gpr_write_reg  = head_rd;
         gpr_write_data = head_data;
      end
      if (a_fpr) begin
         fpr_reg_write  = 1'b1;
         fpr_write_reg  = a_rd;
         fpr_write_data = a_data;
      end else if (head_wr && head_fp) begin
         fpr_reg_write  = 1'b1;
         fpr_write_reg  = head_rd;
         fpr_write_data = head_data;
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (vld_q[i] && (fp_q[i] == chk_is_fp) && (rd_q[i] == chk_rd)) busy = 1'b1;
      end
      chk_busy = busy && (chk_is_fp || (chk_rd != 5'd0));
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      vld_d    = vld_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
         vld_d    = '0;
      end else begin
         if (pop) begin
            rd_ptr_d        = rd_ptr_q + PW'(1);
            vld_d[rd_ptr_q] = 1'b0;
         end
         if (push) begin
            wr_ptr_d        = wr_ptr_q + PW'(1);
            vld_d[wr_ptr_q] = 1'b1;
         end
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         vld_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         vld_q    <= vld_d;
      end
   end

   // Payload needs no reset; the valid bits and count qualify every read.
   always_ff @(posedge clk) begin
      if (push) begin
         fp_q[wr_ptr_q]   <= b_is_fp;
         rd_q[wr_ptr_q]   <= b_rd;
         data_q[wr_ptr_q] <= b_data;
      end
   end

endmodule
